// File: rtl/rs_param_station.sv
// Parametrised reservation station: renamed dispatch, multi-CDB wakeup, age-matrix oldest-first issue to
// NUM_ALU ALU ports and one backpressured LS port. Optional macro RS_WAKEUP_BYPASS_EN enables same-cycle CDB-to-select bypass.
module rs_param_station #(
  parameter int RS_DEPTH = 16,
  parameter int TAG_W    = 4,
  parameter int NUM_ALU  = 2,
  parameter int NUM_CDB  = 2,
  parameter int CNT_W    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [5:0]               disp_op,
  input  logic                     disp_is_ls,
  input  logic [TAG_W-1:0]         disp_rob_tag,
  input  logic                     disp_q1_pend,
  input  logic                     disp_q2_pend,
  input  logic [TAG_W-1:0]         disp_q1_tag,
  input  logic [TAG_W-1:0]         disp_q2_tag,
  input  logic [31:0]              disp_v1,
  input  logic [31:0]              disp_v2,
  input  logic [31:0]              disp_imm,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*32-1:0]    cdb_value,
  output logic [NUM_ALU-1:0]       alu_valid,
  output logic [NUM_ALU*6-1:0]     alu_op,
  output logic [NUM_ALU*32-1:0]    alu_rs1,
  output logic [NUM_ALU*32-1:0]    alu_rs2,
  output logic [NUM_ALU*TAG_W-1:0] alu_rob_dest,
  output logic                     ls_valid,
  input  logic                     ls_ready,
  output logic [5:0]               ls_op,
  output logic [TAG_W-1:0]         ls_rob_tag,
  output logic [31:0]              ls_offset,
  output logic [31:0]              ls_rs1,
  output logic [31:0]              ls_rs2,
  output logic [CNT_W-1:0]         rs_count
);

  typedef struct packed {
    logic [5:0]       op;
    logic             is_ls;
    logic [TAG_W-1:0] rob_tag;
    logic             q1_pend;
    logic [TAG_W-1:0] q1_tag;
    logic [31:0]      v1;
    logic             q2_pend;
    logic [TAG_W-1:0] q2_tag;
    logic [31:0]      v2;
    logic [31:0]      imm;
  } entry_t;

  entry_t              ent_q [RS_DEPTH];
  entry_t              ent_n [RS_DEPTH];
  logic [RS_DEPTH-1:0] busy_q, busy_n;
  // older_q[i][j] set means entry i was dispatched before entry j
  logic [RS_DEPTH-1:0] older_q [RS_DEPTH];
  logic [RS_DEPTH-1:0] older_n [RS_DEPTH];

  logic                disp_acc;
  int                  disp_slot;
  logic [RS_DEPTH-1:0] op_ready, alu_req, ls_req, alu_mask, ls_pick, ls_mask;
  logic [31:0]         sel_v1 [RS_DEPTH];
  logic [31:0]         sel_v2 [RS_DEPTH];
  int                  alu_rank [RS_DEPTH];
  int                  ls_rank [RS_DEPTH];
  int                  n_alu, cnt_n;

  logic [NUM_ALU-1:0]       alu_hit;
  logic [NUM_ALU*6-1:0]     alu_op_n;
  logic [NUM_ALU*32-1:0]    alu_rs1_n, alu_rs2_n;
  logic [NUM_ALU*TAG_W-1:0] alu_dest_n;
  logic                     ls_found, ls_load;
  entry_t                   ls_ent;
  logic [31:0]              ls_v1_n, ls_v2_n;

  // Returns {hit, value}; the lowest-index matching bus wins.
  function automatic logic [32:0] cdb_lookup(input logic [TAG_W-1:0] tag);
    logic [32:0] r;
    r = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--)
      if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == tag)
        r = {1'b1, cdb_value[k*32 +: 32]};
    return r;
  endfunction

  assign disp_ready = (rs_count != CNT_W'(RS_DEPTH));
  assign disp_acc   = disp_valid && disp_ready;

  always_comb begin
    disp_slot = 0;
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (!busy_q[i]) disp_slot = i;
  end

  // Select-side operand view; with the bypass a live CDB match counts as ready.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
      logic [32:0] h1, h2;
      h1 = cdb_lookup(ent_q[i].q1_tag);
      h2 = cdb_lookup(ent_q[i].q2_tag);
      op_ready[i] = (!ent_q[i].q1_pend || h1[32]) && (!ent_q[i].q2_pend || h2[32]);
      sel_v1[i]   = ent_q[i].q1_pend ? h1[31:0] : ent_q[i].v1;
      sel_v2[i]   = ent_q[i].q2_pend ? h2[31:0] : ent_q[i].v2;
`else
      op_ready[i] = !ent_q[i].q1_pend && !ent_q[i].q2_pend;
      sel_v1[i]   = ent_q[i].v1;
      sel_v2[i]   = ent_q[i].v2;
`endif
      alu_req[i] = busy_q[i] && op_ready[i] && !ent_q[i].is_ls;
      ls_req[i]  = busy_q[i] && op_ready[i] && ent_q[i].is_ls;
    end
  end

  // Rank = number of older requesting entries; rank k goes to port k.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      alu_rank[i] = 0;
      ls_rank[i]  = 0;
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (j != i && older_q[j][i]) begin
          if (alu_req[j]) alu_rank[i] = alu_rank[i] + 1;
          if (ls_req[j])  ls_rank[i]  = ls_rank[i] + 1;
        end
      end
    end
  end

  always_comb begin
    alu_hit    = '0;
    alu_op_n   = '0;
    alu_rs1_n  = '0;
    alu_rs2_n  = '0;
    alu_dest_n = '0;
    alu_mask   = '0;
    n_alu      = 0;
    ls_found   = 1'b0;
    ls_pick    = '0;
    ls_ent     = '0;
    ls_v1_n    = '0;
    ls_v2_n    = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int k = 0; k < NUM_ALU; k++) begin
        if (alu_req[i] && alu_rank[i] == k) begin
          alu_hit[k]                    = 1'b1;
          alu_op_n[k*6 +: 6]            = ent_q[i].op;
          alu_rs1_n[k*32 +: 32]         = sel_v1[i];
          alu_rs2_n[k*32 +: 32]         = sel_v2[i];
          alu_dest_n[k*TAG_W +: TAG_W]  = ent_q[i].rob_tag;
          alu_mask[i]                   = 1'b1;
        end
      end
      if (ls_req[i] && ls_rank[i] == 0) begin
        ls_found   = 1'b1;
        ls_pick[i] = 1'b1;
        ls_ent     = ent_q[i];
        ls_v1_n    = sel_v1[i];
        ls_v2_n    = sel_v2[i];
      end
    end
    for (int k = 0; k < NUM_ALU; k++)
      if (alu_hit[k]) n_alu = n_alu + 1;
    ls_load = ls_found && (!ls_valid || ls_ready);
    ls_mask = ls_load ? ls_pick : '0;
  end

  // Entry update: CDB wakeup, dispatch write (with same-cycle capture), issue frees.
  always_comb begin
    logic [32:0] l1, l2;
    l1 = cdb_lookup(disp_q1_tag);
    l2 = cdb_lookup(disp_q2_tag);
    busy_n = busy_q & ~alu_mask & ~ls_mask;
    for (int i = 0; i < RS_DEPTH; i++) begin
      logic [32:0] w1, w2;
      ent_n[i] = ent_q[i];
      w1 = cdb_lookup(ent_q[i].q1_tag);
      w2 = cdb_lookup(ent_q[i].q2_tag);
      if (ent_q[i].q1_pend && w1[32]) begin
        ent_n[i].q1_pend = 1'b0;
        ent_n[i].v1      = w1[31:0];
      end
      if (ent_q[i].q2_pend && w2[32]) begin
        ent_n[i].q2_pend = 1'b0;
        ent_n[i].v2      = w2[31:0];
      end
      if (disp_acc && i == disp_slot) begin
        busy_n[i]        = 1'b1;
        ent_n[i].op      = disp_op;
        ent_n[i].is_ls   = disp_is_ls;
        ent_n[i].rob_tag = disp_rob_tag;
        ent_n[i].q1_tag  = disp_q1_tag;
        ent_n[i].q2_tag  = disp_q2_tag;
        ent_n[i].q1_pend = disp_q1_pend && !l1[32];
        ent_n[i].q2_pend = disp_q2_pend && !l2[32];
        ent_n[i].v1      = disp_q1_pend ? l1[31:0] : disp_v1;
        ent_n[i].v2      = disp_q2_pend ? l2[31:0] : disp_v2;
        ent_n[i].imm     = disp_imm;
      end
    end
  end

  always_comb begin
    for (int s = 0; s < RS_DEPTH; s++) older_n[s] = older_q[s];
    if (disp_acc) begin
      for (int s = 0; s < RS_DEPTH; s++) begin
        if (s == disp_slot) begin
          for (int j = 0; j < RS_DEPTH; j++) begin
            older_n[s][j] = 1'b0;
            older_n[j][s] = (j != s);
          end
        end
      end
    end
    cnt_n = int'(rs_count) + (disp_acc ? 1 : 0) - n_alu - (ls_load ? 1 : 0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q       <= '0;
      rs_count     <= '0;
      alu_valid    <= '0;
      alu_op       <= '0;
      alu_rs1      <= '0;
      alu_rs2      <= '0;
      alu_rob_dest <= '0;
      ls_valid     <= 1'b0;
      ls_op        <= '0;
      ls_rob_tag   <= '0;
      ls_offset    <= '0;
      ls_rs1       <= '0;
      ls_rs2       <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_q[i]   <= '0;
        older_q[i] <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        busy_q    <= '0;
        rs_count  <= '0;
        alu_valid <= '0;
        ls_valid  <= 1'b0;
      end else begin
        busy_q       <= busy_n;
        rs_count     <= CNT_W'(cnt_n);
        alu_valid    <= alu_hit;
        alu_op       <= alu_op_n;
        alu_rs1      <= alu_rs1_n;
        alu_rs2      <= alu_rs2_n;
        alu_rob_dest <= alu_dest_n;
        for (int i = 0; i < RS_DEPTH; i++) begin
          ent_q[i]   <= ent_n[i];
          older_q[i] <= older_n[i];
        end
        // LS data holds while ls_valid waits for ls_ready
        if (ls_load) begin
          ls_valid   <= 1'b1;
          ls_op      <= ls_ent.op;
          ls_rob_tag <= ls_ent.rob_tag;
          ls_offset  <= ls_ent.imm;
          ls_rs1     <= ls_v1_n;
          ls_rs2     <= ls_v2_n;
        end else if (ls_valid && ls_ready) begin
          ls_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/rs_param_station.md
Name: rs_param_station

Overview:
- Parametrised successor of the current 16-entry reservation station. Sits between ROB/rename dispatch and the execution units (NUM_ALU ALUs, one load/store buffer port).
- Dispatch delivers already-renamed operands: each is a value or a ROB tag. No register-file query round trip.
- Adds oldest-first selection, NUM_CDB broadcast buses, a dispatch ready/valid handshake, LSB backpressure, and an occupancy count.

Parameters:
- RS_DEPTH, 16, number of entries (power of 2, 4..64).
- TAG_W, 4, ROB tag width.
- NUM_ALU, 2, ALU issue ports (1..4).
- NUM_CDB, 2, CDB broadcast buses (1..4).
- CNT_W, 5, width of rs_count; must be at least log2(RS_DEPTH)+1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-low reset; reset is applied when rst==0 at posedge clk.
- rdy, input, 1, global enable; 0 freezes all state and outputs.
- flush, input, 1, mispredict flush.
- disp_valid, input, 1, dispatch request.
- disp_ready, output, 1, an entry is free.
- disp_op, input, 6, op code (existing LUI..AND numbering).
- disp_is_ls, input, 1, entry routes to the LS port.
- disp_rob_tag, input, TAG_W, destination ROB tag.
- disp_q1_pend / disp_q2_pend, input, 1 each, operand awaits a tag.
- disp_q1_tag / disp_q2_tag, input, TAG_W each, producer tag.
- disp_v1 / disp_v2, input, 32 each, operand value when not pending.
- disp_imm, input, 32, LS address offset.
- cdb_valid, input, NUM_CDB, broadcast valid per bus.
- cdb_tag, input, NUM_CDB*TAG_W, broadcast tags; bus k in bits [k*TAG_W +: TAG_W].
- cdb_value, input, NUM_CDB*32, broadcast values.
- alu_valid, output, NUM_ALU, one-cycle issue pulse per port.
- alu_op, output, NUM_ALU*6, issued op.
- alu_rs1 / alu_rs2, output, NUM_ALU*32 each, issued operands.
- alu_rob_dest, output, NUM_ALU*TAG_W, issued destination tag.
- ls_valid, output, 1, LS issue valid; held until accepted.
- ls_ready, input, 1, LSB accepts.
- ls_op, output, 6, issued LS op.
- ls_rob_tag, output, TAG_W, issued LS destination tag.
- ls_offset, output, 32, issued LS address offset.
- ls_rs1 / ls_rs2, output, 32 each, issued LS operands.
- rs_count, output, CNT_W, number of occupied entries.

Behaviour:
- Reset (rst==0, takes precedence over rdy): all entries free; alu_valid=0, ls_valid=0, rs_count=0, disp_ready=1. Data outputs reset to 0.
- rdy==0: no state change. Inputs arriving in that cycle are ignored.
- disp_ready = (rs_count != RS_DEPTH), computed from registered state. A slot freed in cycle N does not raise disp_ready until N+1.
- Dispatch accepted when disp_valid && disp_ready. The entry goes to the lowest-index free slot.
- Same-cycle bypass at dispatch: if a pending dispatch operand tag matches any valid CDB tag in that cycle, the value is captured and the operand is marked ready.
- Wakeup: every busy entry compares each pending operand tag against all NUM_CDB buses each cycle. On a match it captures the value.
  - If several buses match, the lowest bus index wins (ROB guarantees unique tags).
- Eligibility:
  - Entries woken in cycle N are selectable from cycle N+1.
  - Newly dispatched entries are selectable from N+1 when both operands are ready at dispatch.
- Age tracking is exact, using an age matrix or equivalent; there are no ties.
- ALU select: the NUM_ALU oldest ready non-LS entries are issued in age order to ports 0..NUM_ALU-1.
  - Outputs are registered: alu_valid pulses in the cycle after selection.
  - Issued entries are freed on the selection edge.
  - Ports with nothing to issue drive valid=0.
- LS select: the oldest ready LS entry is selected only if the output register is empty, or is accepted this cycle (ls_valid && ls_ready).
  - The entry is freed when it is loaded into the output register.
  - ls_valid and the LS data outputs stay stable until ls_ready is seen.
- rs_count next = rs_count + accepted dispatch − entries issued (ALU + LS). Simultaneous dispatch and issue net correctly.
- Flush (checked after rst and rdy):
  - Next edge: all entries free, alu_valid=0, ls_valid=0, rs_count=0.
  - A dispatch or CDB input in the flush cycle is dropped.
- Full with a simultaneous issue: the dispatch is not accepted in that cycle because disp_ready=0.

Optional Feature:
- RS_WAKEUP_BYPASS_EN defined: the select logic also treats an operand as ready if it matches a valid CDB tag in the current cycle. The issued operand value is taken directly from the CDB, so a woken entry issues one cycle earlier (selected in cycle N). Newly dispatched entries are still not selectable in their dispatch cycle.
- RS_WAKEUP_BYPASS_EN undefined: the N+1 eligibility rule above applies.

Test Plan:
- Reset then ADD dispatch, v1=5, v2=7, no pend, tag=3 → alu_valid[0]=1 two edges after dispatch with rs1=5, rs2=7, dest=3; rs_count goes 0→1→0.
- Dispatch SUB with q1 pend tag 9, then cdb_valid[1]=1, tag 9, value 0x10 two cycles later → without the macro, issue pulses 2 edges after the CDB with rs1=0x10; with RS_WAKEUP_BYPASS_EN, 1 edge after.
- Dispatch 3 ready ALU ops with tags 1,2,3 in consecutive cycles while alu outputs are stalled by pending operands, then release them together → with NUM_ALU=2, tags 1 and 2 issue first on ports 0 and 1; tag 3 issues next cycle.
- Fill RS_DEPTH entries with pending ops → disp_ready=0 and rs_count=16. Further disp_valid is ignored. One wakeup then frees a slot → disp_ready=1 one cycle after the issue.
- LS op ready with ls_ready=0 for 4 cycles → ls_valid held and ls_offset stable. A second ready LS stays in the RS. ls_ready=1 → the first is accepted and the second appears on the next edge.
- Flush with 5 busy entries, a dispatch and ls_valid=1 in the same cycle → next cycle rs_count=0, ls_valid=0, alu_valid=0, and the flushed-cycle dispatch is lost. rst=0 mid-operation gives the same result.
